// File: rtl/multicycle_alu_if.sv
// Purpose: request/response bundle between datapath control and the multicycle ALU.
// Latency: none; this is plain wiring.
// Backpressure: the master holds start until the slave shows ready on the edge; done is a pulse.
interface multicycle_alu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  start;
  logic [3:0]            alu_operation;
  logic [DATA_WIDTH-1:0] a;
  logic [DATA_WIDTH-1:0] b;
  logic [4:0]            shamt;
  logic                  ready;
  logic                  done;
  logic [DATA_WIDTH-1:0] result;
  logic                  zero;

  modport master (
    output start, alu_operation, a, b, shamt,
    input  ready, done, result, zero
  );

  modport slave (
    input  start, alu_operation, a, b, shamt,
    output ready, done, result, zero
  );
endinterface

// File: rtl/multicycle_alu.sv
// Purpose: sequential ALU stage with registered result/zero under a start/ready/done handshake.
// Latency: 1 cycle for logic/arith ops, 1 + ceil(shamt/SHIFT_BITS_PER_CYCLE) for SLL/SRL.
// Backpressure: ready drops while shifting; a start seen while not ready is dropped, never queued.
// Build option: define MULTICYCLE_ALU_BARREL_SHIFT_EN for a single-cycle barrel shifter.
module multicycle_alu #(
  parameter int DATA_WIDTH           = 32,
  parameter int SHIFT_BITS_PER_CYCLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  multicycle_alu_if.slave     bus
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;
  localparam logic [3:0] OP_BR  = 4'b1000;
  localparam logic [3:0] OP_JR  = 4'b1001;

  localparam logic [4:0] STEP = 5'(SHIFT_BITS_PER_CYCLE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state;
  logic                  ready_q;
  logic                  done_q;
  logic [DATA_WIDTH-1:0] result_q;
  logic                  zero_q;
  logic [DATA_WIDTH-1:0] sh_val;
  logic                  sh_right;
  logic [4:0]            sh_cnt;

  logic [DATA_WIDTH-1:0] op_res;
  logic [DATA_WIDTH+15:0] lui_full;
  logic                  is_shift;
  logic                  go_shift;
  logic [4:0]            step;
  logic [4:0]            cnt_rem;
  logic [DATA_WIDTH-1:0] shifted;

  // Single-cycle result for the operands presented on the accept edge.
  always_comb begin
    op_res   = '0;
    lui_full = {{DATA_WIDTH{1'b0}}, bus.b[15:0]} << 16;
    case (bus.alu_operation)
      OP_AND: op_res = bus.a & bus.b;
      OP_OR:  op_res = bus.a | bus.b;
      OP_NOR: op_res = ~(bus.a | bus.b);
      OP_ADD: op_res = bus.a + bus.b;
      OP_SUB: op_res = bus.a - bus.b;
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
      OP_SLL: op_res = bus.b << bus.shamt;
      OP_SRL: op_res = bus.b >> bus.shamt;
`else
      // Only reached with shamt == 0; non-zero amounts go to the iterative shifter.
      OP_SLL: op_res = bus.b;
      OP_SRL: op_res = bus.b;
`endif
      OP_LUI: op_res = lui_full[DATA_WIDTH-1:0];
      OP_BR:  op_res = bus.a - bus.b;
      OP_JR:  op_res = bus.a;
      default: op_res = '0;
    endcase
  end

  // Decide whether an accepted request needs the multicycle shift path.
  always_comb begin
    is_shift = (bus.alu_operation == OP_SLL) || (bus.alu_operation == OP_SRL);
`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
    go_shift = 1'b0;
`else
    go_shift = is_shift && (bus.shamt != 5'd0);
`endif
  end

  // One iteration of the shifter: move by min(step size, remaining).
  always_comb begin
    step    = (sh_cnt < STEP) ? sh_cnt : STEP;
    cnt_rem = sh_cnt - step;
    shifted = sh_right ? (sh_val >> step) : (sh_val << step);
  end

  // Control FSM with registered handshake outputs and result/zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      sh_val   <= '0;
      sh_right <= 1'b0;
      sh_cnt   <= 5'd0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            if (go_shift) begin
              state    <= SHIFT;
              ready_q  <= 1'b0;
              done_q   <= 1'b0;
              sh_val   <= bus.b;
              sh_right <= (bus.alu_operation == OP_SRL);
              sh_cnt   <= bus.shamt;
            end else begin
              state    <= DONE;
              ready_q  <= 1'b1;
              done_q   <= 1'b1;
              result_q <= op_res;
              zero_q   <= (op_res == '0);
            end
          end else begin
            state   <= IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        SHIFT: begin
          sh_val <= shifted;
          sh_cnt <= cnt_rem;
          if (cnt_rem == 5'd0) begin
            state    <= DONE;
            ready_q  <= 1'b1;
            done_q   <= 1'b1;
            result_q <= shifted;
            zero_q   <= (shifted == '0);
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b1;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready  = ready_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.zero   = zero_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Purpose: self-checking bench for multicycle_alu using a result scoreboard.
// Latency: checks done timing per operation class against the expected cycle counts.
// Backpressure: exercises ignored starts while busy and back-to-back starts during DONE.
module tb_multicycle_alu;

`ifdef MULTICYCLE_ALU_BARREL_SHIFT_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic clk;
  logic reset;

  multicycle_alu_if #(.DATA_WIDTH(32)) bus ();
  multicycle_alu_if #(.DATA_WIDTH(32)) bus4 ();

  multicycle_alu #(.DATA_WIDTH(32), .SHIFT_BITS_PER_CYCLE(1)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  multicycle_alu #(.DATA_WIDTH(32), .SHIFT_BITS_PER_CYCLE(4)) u_dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4.slave)
  );

  always #5 clk = ~clk;

  // Expected {result, zero}
  logic [32:0] sb[$];
  logic [32:0] sb4[$];
  logic [32:0] exp_v;
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [4:0] sh);
    logic [31:0] r;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = ~(a | b);
      4'd3: r = a + b;
      4'd4: r = a - b;
      4'd5: r = b << sh;
      4'd6: r = b >> sh;
      4'd7: r = {b[15:0], 16'h0000};
      4'd8: r = a - b;
      4'd9: r = a;
      default: r = 32'h0;
    endcase
    return {r, (r == 32'h0)};
  endfunction

  // Present one request on the main DUT and push its expected outcome.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] sh, input logic [32:0] exp);
    sb.push_back(exp);
    bus.alu_operation = op;
    bus.a = a;
    bus.b = b;
    bus.shamt = sh;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Count cycles from the accept edge until done is seen (0 = never seen).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if ({bus.ready, bus.done, bus.result, bus.zero} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_values: got ready=%b done=%b result=%h zero=%b, need 1 0 00000000 1",
               bus.ready, bus.done, bus.result, bus.zero);
    end
  endtask

  task automatic test_add;
    int lat;
    send(4'b0011, 32'h7FFF_FFFF, 32'h1, 5'd0, {32'h8000_0000, 1'b0});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if (lat !== 1) begin
      n_err++;
      $display("FAIL add_latency: got %0d, need 1", lat);
    end
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v) begin
      n_err++;
      $display("FAIL add_result: got %h/%b, need %h/%b", bus.result, bus.zero, exp_v[32:1], exp_v[0]);
    end
  endtask

  task automatic test_branch_nor;
    int lat;
    send(4'b1000, 32'h1234, 32'h1234, 5'd0, {32'h0, 1'b1});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v || lat !== 1) begin
      n_err++;
      $display("FAIL branch_eq: got %h/%b lat %0d, need %h/%b lat 1",
               bus.result, bus.zero, lat, exp_v[32:1], exp_v[0]);
    end
    send(4'b0010, 32'h0, 32'h0, 5'd0, {32'hFFFF_FFFF, 1'b0});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v) begin
      n_err++;
      $display("FAIL nor_zero: got %h/%b, need %h/%b", bus.result, bus.zero, exp_v[32:1], exp_v[0]);
    end
    send(4'b0100, 32'h0, 32'h1, 5'd0, {32'hFFFF_FFFF, 1'b0});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v) begin
      n_err++;
      $display("FAIL sub_wrap: got %h/%b, need %h/%b", bus.result, bus.zero, exp_v[32:1], exp_v[0]);
    end
  endtask

  task automatic test_sll_long;
    int lat;
    int lowc;
    logic [31:0] prev;
    prev = bus.result;
    send(4'b0101, 32'h0, 32'h1, 5'd31, {32'h8000_0000, 1'b0});
    lat = 0;
    lowc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      // Spurious request while busy; must be dropped.
      if (i == 3) begin
        bus.alu_operation = 4'b0000;
        bus.a = 32'h0;
        bus.b = 32'h0;
        bus.start = 1'b1;
      end
      if (i == 4) bus.start = 1'b0;
      if (i == 10) begin
        n_cmp++;
        if (bus.result !== prev) begin
          n_err++;
          $display("FAIL sll_result_held: got %h mid-shift, need %h", bus.result, prev);
        end
      end
      if (bus.ready === 1'b0) lowc++;
      if (bus.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    exp_v = sb.pop_front();
    n_cmp++;
    if (lat !== (BARREL ? 1 : 32)) begin
      n_err++;
      $display("FAIL sll_latency: got %0d, need %0d", lat, BARREL ? 1 : 32);
    end
    n_cmp++;
    if (lowc !== (BARREL ? 0 : 31)) begin
      n_err++;
      $display("FAIL sll_ready_low: got %0d cycles, need %0d", lowc, BARREL ? 0 : 31);
    end
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v) begin
      n_err++;
      $display("FAIL sll_result: got %h/%b, need %h/%b", bus.result, bus.zero, exp_v[32:1], exp_v[0]);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
      n_err++;
      $display("FAIL sll_no_queued_start: got done=%b ready=%b, need 0 1", bus.done, bus.ready);
    end
  endtask

  task automatic test_srl;
    int lat;
    send(4'b0110, 32'h0, 32'hF000_0000, 5'd0, {32'hF000_0000, 1'b0});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v || lat !== 1) begin
      n_err++;
      $display("FAIL srl_shamt0: got %h/%b lat %0d, need %h/%b lat 1",
               bus.result, bus.zero, lat, exp_v[32:1], exp_v[0]);
    end
    // Step-4 instance: shamt 4 takes one shift cycle.
    sb4.push_back({32'h0F00_0000, 1'b0});
    bus4.alu_operation = 4'b0110;
    bus4.a = 32'h0;
    bus4.b = 32'hF000_0000;
    bus4.shamt = 5'd4;
    bus4.start = 1'b1;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    exp_v = sb4.pop_front();
    n_cmp++;
    if (lat !== (BARREL ? 1 : 2)) begin
      n_err++;
      $display("FAIL srl_step4_latency: got %0d, need %0d", lat, BARREL ? 1 : 2);
    end
    n_cmp++;
    if ({bus4.result, bus4.zero} !== exp_v) begin
      n_err++;
      $display("FAIL srl_step4_result: got %h/%b, need %h/%b", bus4.result, bus4.zero, exp_v[32:1], exp_v[0]);
    end
    // Odd remainder: shamt 7 at step 4 takes two shift cycles.
    sb4.push_back(model(4'b0101, 32'h0, 32'h0000_0003, 5'd7));
    bus4.alu_operation = 4'b0101;
    bus4.b = 32'h0000_0003;
    bus4.shamt = 5'd7;
    bus4.start = 1'b1;
    @(posedge clk);
    #1;
    bus4.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus4.done === 1'b1) begin
        lat = i;
        break;
      end
    end
    exp_v = sb4.pop_front();
    n_cmp++;
    if ({bus4.result, bus4.zero} !== exp_v || lat !== (BARREL ? 1 : 3)) begin
      n_err++;
      $display("FAIL sll_step4_rem: got %h/%b lat %0d, need %h/%b lat %0d",
               bus4.result, bus4.zero, lat, exp_v[32:1], exp_v[0], BARREL ? 1 : 3);
    end
  endtask

  task automatic test_lui_misc;
    int lat;
    send(4'b0111, 32'h0, 32'h0000_ABCD, 5'd0, {32'hABCD_0000, 1'b0});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v) begin
      n_err++;
      $display("FAIL lui: got %h/%b, need %h/%b", bus.result, bus.zero, exp_v[32:1], exp_v[0]);
    end
    send(4'b1001, 32'hDEAD_BEEF, 32'h5, 5'd0, {32'hDEAD_BEEF, 1'b0});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v) begin
      n_err++;
      $display("FAIL jr_pass: got %h/%b, need %h/%b", bus.result, bus.zero, exp_v[32:1], exp_v[0]);
    end
    send(4'b1111, 32'h5, 32'h7, 5'd3, {32'h0, 1'b1});
    wait_done(lat);
    exp_v = sb.pop_front();
    n_cmp++;
    if ({bus.result, bus.zero} !== exp_v) begin
      n_err++;
      $display("FAIL op1111_zero: got %h/%b, need %h/%b", bus.result, bus.zero, exp_v[32:1], exp_v[0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 8; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == 4'd5 || op == 4'd6) op = 4'd3;
      a = $urandom;
      b = (i == 0) ? a : $urandom;
      sb.push_back(model(op, a, b, 5'd0));
      bus.alu_operation = op;
      bus.a = a;
      bus.b = b;
      bus.shamt = 5'd0;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      if (i == 7) bus.start = 1'b0;
      @(negedge clk);
      exp_v = sb.pop_front();
      n_cmp++;
      if (bus.done !== 1'b1 || {bus.result, bus.zero} !== exp_v) begin
        n_err++;
        $display("FAIL b2b_%0d: got done=%b %h/%b, need done=1 %h/%b (op %h)",
                 i, bus.done, bus.result, bus.zero, exp_v[32:1], exp_v[0], op);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_end: got done=%b, need 0", bus.done);
    end
  endtask

  task automatic test_reset_mid_shift;
    int lat;
    int extra;
    if (BARREL) begin
      send(4'b0101, 32'h0, 32'h1, 5'd20, {32'h0010_0000, 1'b0});
      wait_done(lat);
      exp_v = sb.pop_front();
      n_cmp++;
      if ({bus.result, bus.zero} !== exp_v || lat !== 1) begin
        n_err++;
        $display("FAIL barrel_sll20: got %h/%b lat %0d, need %h/%b lat 1",
                 bus.result, bus.zero, lat, exp_v[32:1], exp_v[0]);
      end
    end else begin
      // Make the held result non-zero so the reset clear is observable.
      send(4'b1001, 32'h5555_AAAA, 32'h0, 5'd0, {32'h5555_AAAA, 1'b0});
      wait_done(lat);
      exp_v = sb.pop_front();
      bus.alu_operation = 4'b0101;
      bus.a = 32'h0;
      bus.b = 32'h1;
      bus.shamt = 5'd20;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (bus.ready !== 1'b0 || bus.result !== exp_v[32:1]) begin
        n_err++;
        $display("FAIL midshift_busy: got ready=%b result=%h, need 0 %h", bus.ready, bus.result, exp_v[32:1]);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({bus.ready, bus.done, bus.result, bus.zero} !== {1'b1, 1'b0, 32'h0, 1'b1}) begin
        n_err++;
        $display("FAIL midshift_reset: got ready=%b done=%b result=%h zero=%b, need 1 0 00000000 1",
                 bus.ready, bus.done, bus.result, bus.zero);
      end
      @(negedge clk);
      reset = 1'b0;
      extra = 0;
      repeat (30) begin
        @(negedge clk);
        if (bus.done === 1'b1) extra++;
      end
      n_cmp++;
      if (extra !== 0) begin
        n_err++;
        $display("FAIL midshift_no_done: got %0d done pulses, need 0", extra);
      end
    end
  endtask

  initial begin
    clk = 1'b0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.alu_operation = 4'h0;
    bus.a = 32'h0;
    bus.b = 32'h0;
    bus.shamt = 5'd0;
    bus4.start = 1'b0;
    bus4.alu_operation = 4'h0;
    bus4.a = 32'h0;
    bus4.b = 32'h0;
    bus4.shamt = 5'd0;
    #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_add;
    test_branch_nor;
    test_sll_long;
    test_srl;
    test_lui_misc;
    test_back_to_back;
    test_reset_mid_shift;
    if (sb.size() != 0 || sb4.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d/%0d entries left, need 0/0", sb.size(), sb4.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
